// File: rtl/led_display_hub75_driver.sv
// HUB75 LED panel row driver.
//
// Accepts one pixel row (top and bottom half-panel rows, red/green/blue),
// shifts it into the panel MSB column first, blanks, latches with the row
// address, and then enables the panel output for a fixed display period.
//
// row_in layout: six PANEL_W-bit channel fields, channel c at
// row_in[c*PANEL_W +: PANEL_W], ordered {b1,g1,r1,b0,g0,r0} (bits [PANEL_W-1:0]
// are top red). Bit k of each field is column k.
//
// Ports:
//   clk_in, reset_in   clock, synchronous active-high reset
//   row_in             6*PANEL_W pixel row
//   row_valid_in       row_in / row_address_in valid
//   row_address_in     4-bit panel row address
//   brightness_in      8-bit global dimming (only with LED_DISPLAY_HUB75_DIM_EN)
//   row_ready_out      driver idle and able to accept a row
//   hub_rgb_out        {b1,g1,r1,b0,g0,r0}
//   hub_clk_out        panel shift clock
//   hub_lat_out        panel latch
//   hub_oe_n_out       panel output enable, active low
//   hub_addr_out       panel row select A..D
//
// Optional feature: define LED_DISPLAY_HUB75_DIM_EN to add brightness_in.
// Output is then enabled only for the first (DISPLAY_CYCLES*brightness)>>8
// cycles of the display period; the period length itself is unchanged.
//
// state   | meaning
// IDLE    | ready for a row, output disabled
// SHIFT   | clock PANEL_W pixels into the panel, column PANEL_W-1 first
// BLANK   | output disabled for BLANK_CYCLES before latching
// LATCH   | two-cycle latch pulse, row address updated
// DISPLAY | output enabled for the display period

module led_display_hub75_driver #(
    parameter int PANEL_W        = 64,
    parameter int CLK_DIV        = 2,
    parameter int BLANK_CYCLES   = 4,
    parameter int DISPLAY_CYCLES = 1024
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic [6*PANEL_W-1:0] row_in,
    input  logic                 row_valid_in,
    input  logic [3:0]           row_address_in,
`ifdef LED_DISPLAY_HUB75_DIM_EN
    input  logic [7:0]           brightness_in,
`endif
    output logic                 row_ready_out,
    output logic [5:0]           hub_rgb_out,
    output logic                 hub_clk_out,
    output logic                 hub_lat_out,
    output logic                 hub_oe_n_out,
    output logic [3:0]           hub_addr_out
);

    localparam int SHIFT_W = $clog2(PANEL_W + 1);
    localparam int DISP_W  = $clog2(DISPLAY_CYCLES + 1);
    localparam int DIV_W   = $clog2(2 * CLK_DIV);
    localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int COL_W   = (PANEL_W > 1) ? $clog2(PANEL_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t               state, state_next;
    logic [6*PANEL_W-1:0] row_buf;
    logic [3:0]           addr_cap;
    logic [3:0]           addr_q;
    logic [SHIFT_W-1:0]   pix_cnt;     // pixels still to shift, current column is pix_cnt-1
    logic [DIV_W-1:0]     div_cnt;     // counts one pixel period down; low half is clock high
    logic [BLANK_W-1:0]   blank_cnt;
    logic                 lat_cnt;
    logic [DISP_W-1:0]    disp_cnt;
    logic [COL_W-1:0]     col;
    logic [PANEL_W-1:0]   chan [6];

`ifdef LED_DISPLAY_HUB75_DIM_EN
    localparam int PROD_W = DISP_W + 8;
    logic [PROD_W-1:0] on_prod;
    // Output is on while the remaining count is at or above this threshold,
    // i.e. for the first DISPLAY_CYCLES - disp_off cycles.
    logic [DISP_W-1:0] disp_off;

    always_comb begin
        on_prod = PROD_W'(DISPLAY_CYCLES) * PROD_W'(brightness_in);
    end
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (row_valid_in) state_next = SHIFT;
            SHIFT:   if (div_cnt == '0 && pix_cnt == SHIFT_W'(1))
                         state_next = (BLANK_CYCLES == 0) ? LATCH : BLANK;
            BLANK:   if (blank_cnt == '0) state_next = LATCH;
            LATCH:   if (lat_cnt) state_next = DISPLAY;
            DISPLAY: if (disp_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            row_buf   <= '0;
            addr_cap  <= '0;
            addr_q    <= '0;
            pix_cnt   <= '0;
            div_cnt   <= '0;
            blank_cnt <= '0;
            lat_cnt   <= 1'b0;
            disp_cnt  <= '0;
`ifdef LED_DISPLAY_HUB75_DIM_EN
            disp_off  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (row_valid_in) begin
                        row_buf   <= row_in;
                        addr_cap  <= row_address_in;
                        pix_cnt   <= SHIFT_W'(PANEL_W);
                        div_cnt   <= DIV_W'(2 * CLK_DIV - 1);
                        blank_cnt <= BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
                        lat_cnt   <= 1'b0;
                        disp_cnt  <= DISP_W'(DISPLAY_CYCLES - 1);
`ifdef LED_DISPLAY_HUB75_DIM_EN
                        disp_off  <= DISP_W'(DISPLAY_CYCLES) - on_prod[PROD_W-1:8];
`endif
                    end
                end
                SHIFT: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_W'(2 * CLK_DIV - 1);
                        pix_cnt <= pix_cnt - SHIFT_W'(1);
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                BLANK:   if (blank_cnt != '0) blank_cnt <= blank_cnt - BLANK_W'(1);
                LATCH:   lat_cnt <= 1'b1;
                DISPLAY: if (disp_cnt != '0) disp_cnt <= disp_cnt - DISP_W'(1);
                default: ;
            endcase
            // Address becomes visible on the first LATCH cycle and nowhere else.
            if (state_next == LATCH && state != LATCH) begin
                addr_q <= addr_cap;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 6; c++) begin
            chan[c] = row_buf[c*PANEL_W +: PANEL_W];
        end
        col = COL_W'(pix_cnt - SHIFT_W'(1));
    end

    always_comb begin
        row_ready_out = 1'b0;
        hub_rgb_out   = '0;
        hub_clk_out   = 1'b0;
        hub_lat_out   = 1'b0;
        hub_oe_n_out  = 1'b1;
        hub_addr_out  = addr_q;
        case (state)
            IDLE:  row_ready_out = !reset_in;
            SHIFT: begin
                hub_clk_out = (div_cnt < DIV_W'(CLK_DIV));
                for (int c = 0; c < 6; c++) begin
                    hub_rgb_out[c] = chan[c][col];
                end
            end
            LATCH: hub_lat_out = 1'b1;
            DISPLAY: begin
`ifdef LED_DISPLAY_HUB75_DIM_EN
                hub_oe_n_out = !(disp_cnt >= disp_off);
`else
                hub_oe_n_out = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_display_hub75_driver.sv
// Directed testbench for led_display_hub75_driver at default parameters.
// A negedge monitor records shift-clock edges, pixel data at each edge,
// latch/enable cycle counts, the address at each latch pulse, and protocol
// violations; the directed sequence compares these against hand-computed values.

module tb_led_display_hub75_driver;

    logic         clk_in = 1'b0;
    logic         reset_in = 1'b1;
    logic [383:0] row_in = '0;
    logic         row_valid_in = 1'b0;
    logic [3:0]   row_address_in = '0;
    logic [7:0]   brightness_in = 8'hFF;
    logic         row_ready_out;
    logic [5:0]   hub_rgb_out;
    logic         hub_clk_out;
    logic         hub_lat_out;
    logic         hub_oe_n_out;
    logic [3:0]   hub_addr_out;

`ifdef LED_DISPLAY_HUB75_DIM_EN
    localparam int FULL_OE = 1020;   // (1024*255)>>8
`else
    localparam int FULL_OE = 1024;
`endif

    led_display_hub75_driver dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .row_in         (row_in),
        .row_valid_in   (row_valid_in),
        .row_address_in (row_address_in),
`ifdef LED_DISPLAY_HUB75_DIM_EN
        .brightness_in  (brightness_in),
`endif
        .row_ready_out  (row_ready_out),
        .hub_rgb_out    (hub_rgb_out),
        .hub_clk_out    (hub_clk_out),
        .hub_lat_out    (hub_lat_out),
        .hub_oe_n_out   (hub_oe_n_out),
        .hub_addr_out   (hub_addr_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    int         edge_total = 0;
    int         lat_total = 0;
    int         oe_low_total = 0;
    int         lat_viol = 0;
    int         addr_viol = 0;
    logic [5:0] rgb_hist[$];
    logic [3:0] addr_hist[$];
    logic       prev_clk = 1'b0;
    logic       prev_lat = 1'b0;
    logic       prev_rst = 1'b1;
    logic [3:0] prev_addr = 4'h0;

    always @(negedge clk_in) begin
        if (hub_clk_out === 1'b1 && prev_clk !== 1'b1) begin
            edge_total++;
            rgb_hist.push_back(hub_rgb_out);
        end
        if (hub_lat_out === 1'b1) lat_total++;
        if (hub_lat_out === 1'b1 && prev_lat !== 1'b1) addr_hist.push_back(hub_addr_out);
        if (hub_oe_n_out === 1'b0) oe_low_total++;
        if (hub_lat_out === 1'b1 && (hub_oe_n_out !== 1'b1 || hub_clk_out !== 1'b0)) lat_viol++;
        if (hub_addr_out !== prev_addr && hub_lat_out !== 1'b1 && !reset_in && !prev_rst) addr_viol++;
        prev_clk  = hub_clk_out;
        prev_lat  = hub_lat_out;
        prev_rst  = reset_in;
        prev_addr = hub_addr_out;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (row_ready_out !== 1'b1 && n < 3000);
    endtask

    // Sends one row from an idle driver and checks its whole row period.
    task automatic run_row(input string tag, input logic [383:0] r, input logic [3:0] a,
                           input logic [7:0] br, input int exp_oe);
        int n, e0, l0, o0, h0, a0;
        logic [63:0] got;
        if (row_ready_out !== 1'b1) wait_ready(n);
        e0 = edge_total; l0 = lat_total; o0 = oe_low_total;
        h0 = rgb_hist.size(); a0 = addr_hist.size();
        row_in = r; row_address_in = a; brightness_in = br; row_valid_in = 1'b1;
        tick();
        row_valid_in = 1'b0;
        check({tag, "_ready_drop"}, 64'(row_ready_out), 64'd0);
        wait_ready(n);
        check({tag, "_latency"}, 64'(n + 1), 64'd1287);
        check({tag, "_edges"}, 64'(edge_total - e0), 64'd64);
        check({tag, "_lat_cycles"}, 64'(lat_total - l0), 64'd2);
        check({tag, "_oe_low"}, 64'(oe_low_total - o0), 64'(exp_oe));
        check({tag, "_addr"}, (a0 < addr_hist.size()) ? 64'(addr_hist[a0]) : 64'hDEAD, 64'(a));
        for (int c = 0; c < 6; c++) begin
            got = '0;
            for (int k = 0; k < 64; k++) begin
                if (h0 + k < rgb_hist.size()) got[63-k] = rgb_hist[h0+k][c];
            end
            check($sformatf("%s_chan%0d", tag, c), got, r[c*64 +: 64]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [383:0] r1, r2;
        int n, a0, e0;

        // Reset held for three edges, then released.
        tick();
        check("rst_ready_during", 64'(row_ready_out), 64'd0);
        tick();
        tick();
        reset_in = 1'b0;
        tick();
        check("rst_ready_after", 64'(row_ready_out), 64'd1);
        check("rst_oe_n", 64'(hub_oe_n_out), 64'd1);
        check("rst_addr", 64'(hub_addr_out), 64'd0);
        check("rst_lat", 64'(hub_lat_out), 64'd0);
        check("rst_rgb", 64'(hub_rgb_out), 64'd0);
        repeat (5) tick();
        check("rst_no_edges", 64'(edge_total), 64'd0);

        // Single row: top red has only columns 63 and 0 lit.
        r1 = '0;
        r1[63:0] = 64'h8000_0000_0000_0001;
        run_row("row1", r1, 4'h5, 8'hFF, FULL_OE);

        // Continuous valid with incrementing address, 17 rows.
        a0 = addr_hist.size();
        row_in = r1;
        for (int i = 0; i < 17; i++) begin
            row_address_in = 4'(i % 16);
            row_valid_in = 1'b1;
            tick();
            check($sformatf("stream_ready_drop%0d", i), 64'(row_ready_out), 64'd0);
            wait_ready(n);
            check($sformatf("stream_period%0d", i), 64'(n + 1), 64'd1287);
        end
        row_valid_in = 1'b0;
        for (int i = 0; i < 17; i++) begin
            check($sformatf("stream_addr%0d", i),
                  (a0 + i < addr_hist.size()) ? 64'(addr_hist[a0+i]) : 64'hDEAD, 64'(i % 16));
        end
        tick();

        // Reset at shift edge 30, then a full row after release.
        r2 = '0;
        r2[63:0]    = 64'hA5A5_0F0F_1234_5678;
        r2[127:64]  = 64'h0123_4567_89AB_CDEF;
        r2[383:320] = 64'hFEDC_BA98_7654_3210;
        row_in = r2; row_address_in = 4'h9; row_valid_in = 1'b1;
        tick();
        row_valid_in = 1'b0;
        e0 = edge_total;
        n = 0;
        while (edge_total - e0 < 30 && n < 1000) begin
            tick();
            n++;
        end
        check("midrst_edge30", 64'(edge_total - e0), 64'd30);
        reset_in = 1'b1;
        tick();
        check("midrst_clk", 64'(hub_clk_out), 64'd0);
        check("midrst_oe_n", 64'(hub_oe_n_out), 64'd1);
        check("midrst_ready", 64'(row_ready_out), 64'd0);
        check("midrst_rgb", 64'(hub_rgb_out), 64'd0);
        reset_in = 1'b0;
        tick();
        check("midrst_ready_after", 64'(row_ready_out), 64'd1);
        check("midrst_addr", 64'(hub_addr_out), 64'd0);
        check("midrst_edges_stop", 64'(edge_total - e0), 64'd30);
        run_row("row2", r2, 4'hA, 8'hFF, FULL_OE);

`ifdef LED_DISPLAY_HUB75_DIM_EN
        run_row("dim40", r1, 4'h3, 8'h40, 256);
        run_row("dim00", r2, 4'hC, 8'h00, 0);
`endif

        check("lat_violations", 64'(lat_viol), 64'd0);
        check("addr_violations", 64'(addr_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_display_hub75_driver.md
LED_DISPLAY_HUB75_DRIVER -- requirements
Module: led_display_hub75_driver

Interface
REQ-001 SHALL have parameter PANEL_W, default 64, meaning pixels per half-panel row (one bit per colour per pixel).
REQ-002 SHALL have parameter CLK_DIV, default 2, meaning clk_in cycles per hub_clk_out phase (high or low); legal range >=1.
REQ-003 SHALL have parameter BLANK_CYCLES, default 4, meaning cycles hub_oe_n_out is held high before latching.
REQ-004 SHALL have parameter DISPLAY_CYCLES, default 1024, meaning cycles per row display period; legal range >=1.
REQ-005 SHALL use one clock and a synchronous, active-high reset; all logic is clocked on the rising edge of clk_in.
REQ-006 clk_in  input  1  system clock.
REQ-007 reset_in  input  1  synchronous active-high reset.
REQ-008 row_in  input  GL_RGB_ROW_W  rgb_row_t pixel row, top and bottom halves, red/green/blue.
REQ-009 row_valid_in  input  1  row_in and row_address_in valid this cycle.
REQ-010 row_address_in  input  4  panel row address for row_in.
REQ-011 row_ready_out  output  1  driver can accept a row.
REQ-012 hub_rgb_out  output  6  {b1,g1,r1,b0,g0,r0}; index 0 is top, index 1 is bottom.
REQ-013 hub_clk_out  output  1  panel shift clock.
REQ-014 hub_lat_out  output  1  panel latch.
REQ-015 hub_oe_n_out  output  1  panel output enable, active low.
REQ-016 hub_addr_out  output  4  panel row select A..D.

Function
REQ-017 SHALL implement states IDLE, SHIFT, BLANK, LATCH, DISPLAY.
REQ-018 IDLE: row_ready_out=1, hub_oe_n_out=1.
- On row_valid_in=1, capture row_in and row_address_in into internal registers.
- Next state is SHIFT.
- row_valid_in SHALL be ignored in every other state.
REQ-019 row_ready_out SHALL be 0 in every state except IDLE.
- It SHALL deassert in the cycle after acceptance.
- Valid pulses lasting a single cycle SHALL be captured.
REQ-020 SHIFT: shift PANEL_W pixels.
- Send column PANEL_W-1 first and column 0 last.
- Per pixel, drive hub_rgb_out with hub_clk_out=0 for CLK_DIV cycles, then hub_clk_out=1 for CLK_DIV cycles with hub_rgb_out unchanged.
- Total duration is PANEL_W*2*CLK_DIV cycles; hub_clk_out SHALL be 0 on exit.
REQ-021 SHIFT SHALL produce exactly PANEL_W rising edges of hub_clk_out.
- hub_clk_out SHALL be 0 in all other states.
REQ-022 BLANK: hub_oe_n_out=1 for BLANK_CYCLES cycles; BLANK_CYCLES=0 skips the state.
REQ-023 LATCH: lasts 2 cycles.
- hub_lat_out=1 for both cycles.
- hub_addr_out SHALL take the captured address on the first LATCH cycle.
- hub_oe_n_out remains 1.
REQ-024 DISPLAY: hub_oe_n_out=0 for DISPLAY_CYCLES cycles (subject to REQ-033), then return to IDLE.
- hub_addr_out and panel data SHALL remain stable throughout.
REQ-025 hub_lat_out SHALL never be 1 while hub_oe_n_out=0 or hub_clk_out=1.
REQ-026 hub_addr_out SHALL change only in LATCH.
REQ-027 The shift counter SHALL be sized ceil(log2(PANEL_W+1)) bits.
- The display counter SHALL be sized ceil(log2(DISPLAY_CYCLES+1)) bits.
- Neither counter SHALL wrap mid-state.
REQ-028 Row period with no idle gap is 1 + PANEL_W*2*CLK_DIV + BLANK_CYCLES + 2 + DISPLAY_CYCLES cycles.

Reset
REQ-029 Reset in any state, including mid-SHIFT or mid-DISPLAY, SHALL return to IDLE on the next edge.
- The partial row is discarded.
REQ-030 During and after reset, until the first accept:
- row_ready_out=0 while reset_in=1, and 1 thereafter.
- hub_oe_n_out=1.
- hub_clk_out=0, hub_lat_out=0, hub_rgb_out=0, hub_addr_out=0.
- Row buffer cleared.

Configuration
REQ-031 Macro LED_DISPLAY_HUB75_DIM_EN SHALL control global dimming.
REQ-032 Defined: add input brightness_in (8 bits), sampled at row acceptance.
REQ-033 Defined: in DISPLAY, hub_oe_n_out=0 only for the first (DISPLAY_CYCLES*brightness)>>8 cycles.
- hub_oe_n_out=1 for the rest of DISPLAY.
- DISPLAY length is unchanged.
- brightness 0 SHALL never enable output.
REQ-034 Undefined: brightness_in is absent and hub_oe_n_out=0 for the whole DISPLAY state.

Verification
REQ-035 Reset for 3 cycles then release -> row_ready_out=1, hub_oe_n_out=1, hub_addr_out=0, no hub_clk_out edges.
REQ-036 Defaults; accept row with top.red=64'h8000_0000_0000_0001, address 4'h5:
- 64 hub_clk_out rising edges; r0=1 on edges 1 and 64 only.
- hub_lat_out high 2 cycles; hub_addr_out=5.
- hub_oe_n_out low 1024 cycles; row_ready_out reasserts 1 + 256 + 4 + 2 + 1024 = 1287 cycles after acceptance.
REQ-037 Hold row_valid_in=1 continuously with an incrementing address -> one row accepted per row period; addresses appear 0,1,2,...,15,0 with wrap.
REQ-038 Assert reset_in at shift edge 30 -> next cycle in IDLE, hub_clk_out=0, hub_oe_n_out=1; a new row after release shifts all 64 pixels.
REQ-039 With LED_DISPLAY_HUB75_DIM_EN, brightness 8'h40 -> hub_oe_n_out low 256 of 1024 DISPLAY cycles; brightness 0 -> never low.
REQ-040 Check every cycle: hub_lat_out never high with hub_oe_n_out=0; hub_addr_out changes only in LATCH.
